skid_buffer: RTL and testbench



---
 rtl/skid_pkg.sv | 20 ++
 rtl/skid_reg.sv | 40 ++++
 rtl/skid_buffer.sv | 130 +++++++++++++
 tb/tb_skid_buffer.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/skid_pkg.sv
`default_nettype none
// ============================================================================
// Module      : skid_pkg
// Description : Shared types and defaults for the two-entry skid buffer.
// Revision    : 1.0 - initial release
// ============================================================================
package skid_pkg;

  // Default data word width in bits.
  localparam int DEFAULT_WIDTH = 16;

  // Buffer occupancy, decoded from the output and skid valid flags.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_e;

endpackage : skid_pkg
`default_nettype wire

// File: rtl/skid_reg.sv
`default_nettype none
// ============================================================================
// Module      : skid_reg
// Description : Data + valid register with a data load enable. The valid flag
//               takes its next value every cycle; data updates only on load.
// Revision    : 1.0 - initial release
// ============================================================================
module skid_reg #(
  parameter int WIDTH = 16
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_valid_next,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid
);

  logic [WIDTH-1:0] r_data;
  logic             r_valid;

  // Data holds unless loaded; valid follows the next-state value each edge.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_data  <= '0;
      r_valid <= 1'b0;
    end else begin
      if (i_load) begin
        r_data <= i_data;
      end
      r_valid <= i_valid_next;
    end
  end

  assign o_data  = r_data;
  assign o_valid = r_valid;

endmodule : skid_reg
`default_nettype wire

// File: rtl/skid_buffer.sv
`default_nettype none
// ============================================================================
// Module      : skid_buffer
// Description : Two-entry valid/ready skid buffer. Data, valid and ready are
//               all registered, so o_in_ready never depends combinationally on
//               i_out_ready, while still sustaining one word per cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module skid_buffer
  import skid_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic [WIDTH-1:0] i_in_data,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  output logic [WIDTH-1:0] o_out_data,
  output logic             o_out_valid,
  input  logic             i_out_ready
);

  logic [WIDTH-1:0] r_out_data;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_skid_data;
  logic             r_skid_valid;
  logic             r_in_ready;

  logic             w_in_xfer;
  logic             w_out_xfer;
  occ_e             w_occ;

  logic             w_out_load;
  logic [WIDTH-1:0] w_out_din;
  logic             w_out_valid_next;
  logic             w_skid_load;
  logic             w_skid_valid_next;

  assign w_in_xfer  = i_in_valid & r_in_ready;
  assign w_out_xfer = r_out_valid & i_out_ready;

  // Decode occupancy from the two valid flags; skid valid alone cannot occur.
  always_comb begin
    w_occ = EMPTY;
    if (r_out_valid) begin
      w_occ = r_skid_valid ? FULL : ONE;
    end
  end

  // Next-state and load controls for the output and skid stages.
  always_comb begin
    w_out_load        = 1'b0;
    w_out_din         = i_in_data;
    w_out_valid_next  = r_out_valid;
    w_skid_load       = 1'b0;
    w_skid_valid_next = r_skid_valid;
    case (w_occ)
      EMPTY: begin
        if (w_in_xfer) begin
          w_out_load       = 1'b1;
          w_out_valid_next = 1'b1;
        end
      end
      ONE: begin
        if (w_in_xfer && w_out_xfer) begin
          // Pass-through: the new word replaces the one leaving.
          w_out_load = 1'b1;
        end else if (w_in_xfer) begin
          // Downstream stalled: park the new word in the skid stage.
          w_skid_load       = 1'b1;
          w_skid_valid_next = 1'b1;
        end else if (w_out_xfer) begin
          w_out_valid_next = 1'b0;
        end
      end
      FULL: begin
        // Ready is low here, so only the drain of the output stage matters.
        if (w_out_xfer) begin
          w_out_load        = 1'b1;
          w_out_din         = r_skid_data;
          w_skid_valid_next = 1'b0;
        end
      end
      default: begin
        w_out_valid_next  = 1'b0;
        w_skid_valid_next = 1'b0;
      end
    endcase
  end

  skid_reg #(
    .WIDTH (WIDTH)
  ) u_out_reg (
    .i_clock      (i_clock),
    .i_reset      (i_reset),
    .i_load       (w_out_load),
    .i_data       (w_out_din),
    .i_valid_next (w_out_valid_next),
    .o_data       (r_out_data),
    .o_valid      (r_out_valid)
  );

  skid_reg #(
    .WIDTH (WIDTH)
  ) u_skid_reg (
    .i_clock      (i_clock),
    .i_reset      (i_reset),
    .i_load       (w_skid_load),
    .i_data       (i_in_data),
    .i_valid_next (w_skid_valid_next),
    .o_data       (r_skid_data),
    .o_valid      (r_skid_valid)
  );

  // Ready is low in reset and then tracks whether the skid stage will be free.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_in_ready <= 1'b0;
    end else begin
      r_in_ready <= ~w_skid_valid_next;
    end
  end

  assign o_in_ready  = r_in_ready;
  assign o_out_data  = r_out_data;
  assign o_out_valid = r_out_valid;

endmodule : skid_buffer
`default_nettype wire

// File: tb/tb_skid_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_skid_buffer
// Description : Directed self-checking bench for skid_buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_skid_buffer;

  localparam int W = 16;

  logic         i_clock     = 1'b0;
  logic         i_reset     = 1'b1;
  logic [W-1:0] i_in_data   = '0;
  logic         i_in_valid  = 1'b0;
  logic         i_out_ready = 1'b0;
  logic         o_in_ready;
  logic [W-1:0] o_out_data;
  logic         o_out_valid;

  int checks   = 0;
  int failures = 0;

  skid_buffer #(
    .WIDTH (W)
  ) dut (
    .i_clock     (i_clock),
    .i_reset     (i_reset),
    .i_in_data   (i_in_data),
    .i_in_valid  (i_in_valid),
    .o_in_ready  (o_in_ready),
    .o_out_data  (o_out_data),
    .o_out_valid (o_out_valid),
    .i_out_ready (i_out_ready)
  );

  always #5 i_clock = ~i_clock;

  // Drive one cycle of inputs at posedge+1, report which transfers the next
  // edge performs (from the registered outputs), then move to posedge+1.
  task automatic step(input logic v, input logic [W-1:0] d, input logic r,
                      output logic acc, output logic dlv, output logic [W-1:0] dd);
    i_in_valid  = v;
    i_in_data   = d;
    i_out_ready = r;
    acc = v & o_in_ready;
    dlv = o_out_valid & r;
    dd  = o_out_data;
    @(posedge i_clock);
    #1;
  endtask

  task automatic test_reset();
    @(posedge i_clock);
    #1;
    checks++;
    if (o_out_valid !== 1'b0) begin
      failures++; $display("FAIL reset_out_valid: got %b expected 0", o_out_valid);
    end
    checks++;
    if (o_in_ready !== 1'b0) begin
      failures++; $display("FAIL reset_in_ready: got %b expected 0", o_in_ready);
    end
    checks++;
    if (o_out_data !== 16'h0000) begin
      failures++; $display("FAIL reset_out_data: got %h expected 0000", o_out_data);
    end
  endtask

  task automatic test_idle();
    logic acc, dlv;
    logic [W-1:0] dd;
    int n_dlv = 0;
    i_reset = 1'b0;
    #1;
    checks++;
    if (o_in_ready !== 1'b0) begin
      failures++; $display("FAIL idle_ready_before_edge: got %b expected 0", o_in_ready);
    end
    step(1'b0, '0, 1'b0, acc, dlv, dd);
    checks++;
    if (o_in_ready !== 1'b1) begin
      failures++; $display("FAIL idle_ready_first_edge: got %b expected 1", o_in_ready);
    end
    for (int c = 0; c < 100; c++) begin
      step(1'b0, '0, 1'b0, acc, dlv, dd);
      if (dlv) n_dlv++;
      checks++;
      if (o_out_valid !== 1'b0) begin
        failures++; $display("FAIL idle_out_valid cycle %0d: got %b expected 0", c, o_out_valid);
      end
    end
    checks++;
    if (n_dlv !== 0) begin
      failures++; $display("FAIL idle_outputs: got %0d expected 0", n_dlv);
    end
  endtask

  task automatic test_backpressure();
    logic acc, dlv;
    logic [W-1:0] dd;
    logic [W-1:0] src = '0;
    int n_acc = 0;
    for (int c = 0; c < 100; c++) begin
      step(1'b1, src, 1'b0, acc, dlv, dd);
      if (acc) begin
        src = src + 16'd2;
        n_acc++;
      end
      if (n_acc == 2) begin
        checks++;
        if (o_out_data !== 16'h0000 || o_out_valid !== 1'b1) begin
          failures++;
          $display("FAIL bp_hold cycle %0d: got valid=%b data=%h expected valid=1 data=0000",
                   c, o_out_valid, o_out_data);
        end
      end
    end
    checks++;
    if (n_acc !== 2) begin
      failures++; $display("FAIL bp_accepted: got %0d expected 2", n_acc);
    end
    checks++;
    if (o_in_ready !== 1'b0) begin
      failures++; $display("FAIL bp_in_ready: got %b expected 0", o_in_ready);
    end
  endtask

  task automatic test_drain();
    logic acc, dlv;
    logic [W-1:0] dd;
    int n_dlv = 0;
    step(1'b0, '0, 1'b1, acc, dlv, dd);
    if (dlv) n_dlv++;
    checks++;
    if (dlv !== 1'b1 || dd !== 16'h0000) begin
      failures++; $display("FAIL drain_first: got valid=%b data=%h expected valid=1 data=0000", dlv, dd);
    end
    step(1'b0, '0, 1'b1, acc, dlv, dd);
    if (dlv) n_dlv++;
    checks++;
    if (dlv !== 1'b1 || dd !== 16'h0002) begin
      failures++; $display("FAIL drain_second: got valid=%b data=%h expected valid=1 data=0002", dlv, dd);
    end
    for (int c = 0; c < 5; c++) begin
      step(1'b0, '0, 1'b1, acc, dlv, dd);
      if (dlv) n_dlv++;
    end
    checks++;
    if (o_out_valid !== 1'b0) begin
      failures++; $display("FAIL drain_empty: got %b expected 0", o_out_valid);
    end
    checks++;
    if (n_dlv !== 2) begin
      failures++; $display("FAIL drain_count: got %0d expected 2", n_dlv);
    end
  endtask

  task automatic test_streaming();
    logic acc, dlv;
    logic [W-1:0] dd;
    for (int i = 0; i <= 20; i++) begin
      step(1'b1, W'(i), 1'b1, acc, dlv, dd);
      checks++;
      if (acc !== 1'b1) begin
        failures++; $display("FAIL stream_accept %0d: got %b expected 1", i, acc);
      end
      if (i == 0) begin
        checks++;
        if (dlv !== 1'b0) begin
          failures++; $display("FAIL stream_latency: got %b expected 0", dlv);
        end
      end else begin
        checks++;
        if (dlv !== 1'b1 || dd !== W'(i - 1)) begin
          failures++;
          $display("FAIL stream_word %0d: got valid=%b data=%h expected valid=1 data=%h",
                   i, dlv, dd, W'(i - 1));
        end
      end
    end
    step(1'b0, '0, 1'b1, acc, dlv, dd);
    checks++;
    if (dlv !== 1'b1 || dd !== 16'd20) begin
      failures++; $display("FAIL stream_last: got valid=%b data=%h expected valid=1 data=0014", dlv, dd);
    end
    checks++;
    if (o_out_valid !== 1'b0) begin
      failures++; $display("FAIL stream_empty: got %b expected 0", o_out_valid);
    end
  endtask

  task automatic test_bursty();
    logic acc, dlv, rdy;
    logic [W-1:0] dd;
    logic [W-1:0] src = '0;
    logic [W-1:0] nxt = '0;
    int n_acc = 0;
    int n_dlv = 0;
    int occ;
    for (int c = 0; c < 46; c++) begin
      // Ready pattern: 2 on, 3 off, 4 on, 5 off (period 14); drain at the end.
      rdy = ((c % 14) < 2) || (((c % 14) >= 5) && ((c % 14) < 9)) || (c >= 42);
      occ = n_acc - n_dlv;
      checks++;
      if (o_in_ready !== (occ != 2) || o_out_valid !== (occ != 0)) begin
        failures++;
        $display("FAIL bursty_flags cycle %0d: got ready=%b valid=%b expected ready=%b valid=%b",
                 c, o_in_ready, o_out_valid, (occ != 2), (occ != 0));
      end
      step(c < 42, src, rdy, acc, dlv, dd);
      if (acc) begin
        src = src + 16'd3;
        n_acc++;
      end
      if (dlv) begin
        checks++;
        if (dd !== nxt) begin
          failures++; $display("FAIL bursty_order cycle %0d: got %h expected %h", c, dd, nxt);
        end
        nxt = nxt + 16'd3;
        n_dlv++;
      end
    end
    checks++;
    if (n_dlv !== n_acc || o_out_valid !== 1'b0) begin
      failures++;
      $display("FAIL bursty_totals: got delivered=%0d valid=%b expected delivered=%0d valid=0",
               n_dlv, o_out_valid, n_acc);
    end
  endtask

  task automatic test_mid_reset();
    logic acc, dlv;
    logic [W-1:0] dd;
    step(1'b1, 16'h0011, 1'b0, acc, dlv, dd);
    step(1'b1, 16'h0022, 1'b0, acc, dlv, dd);
    step(1'b0, '0, 1'b0, acc, dlv, dd);
    checks++;
    if (o_in_ready !== 1'b0 || o_out_valid !== 1'b1) begin
      failures++; $display("FAIL mr_full: got ready=%b valid=%b expected ready=0 valid=1", o_in_ready, o_out_valid);
    end
    #3;
    i_reset = 1'b1;
    #1;
    checks++;
    if (o_out_valid !== 1'b0 || o_in_ready !== 1'b0 || o_out_data !== 16'h0000) begin
      failures++;
      $display("FAIL mr_async: got valid=%b ready=%b data=%h expected valid=0 ready=0 data=0000",
               o_out_valid, o_in_ready, o_out_data);
    end
    @(posedge i_clock);
    #3;
    i_reset = 1'b0;
    @(posedge i_clock);
    #1;
    checks++;
    if (o_in_ready !== 1'b1 || o_out_valid !== 1'b0) begin
      failures++; $display("FAIL mr_release: got ready=%b valid=%b expected ready=1 valid=0", o_in_ready, o_out_valid);
    end
    step(1'b1, 16'hABCD, 1'b1, acc, dlv, dd);
    step(1'b1, 16'h1234, 1'b1, acc, dlv, dd);
    checks++;
    if (dlv !== 1'b1 || dd !== 16'hABCD) begin
      failures++; $display("FAIL mr_first_word: got valid=%b data=%h expected valid=1 data=abcd", dlv, dd);
    end
    step(1'b0, '0, 1'b1, acc, dlv, dd);
    checks++;
    if (dlv !== 1'b1 || dd !== 16'h1234) begin
      failures++; $display("FAIL mr_second_word: got valid=%b data=%h expected valid=1 data=1234", dlv, dd);
    end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_backpressure();
    test_drain();
    test_streaming();
    test_bursty();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_skid_buffer
`default_nettype wire
